// File: rtl/trig_cnt_pkg.sv
// Shared definitions for the trigger-driven up/down counter: trigger, mode and
// status bit positions plus the auto-run FSM state type.
package trig_cnt_pkg;

  localparam int TRIG_CLEAR       = 0;
  localparam int TRIG_UP          = 1;
  localparam int TRIG_DOWN        = 2;
  localparam int TRIG_LOAD        = 3;
  localparam int TRIG_CAPTURE     = 4;
  localparam int TRIG_CLEAR_FLAGS = 5;
  localparam int TRIG_RUN_START   = 6;
  localparam int TRIG_RUN_STOP    = 7;

  localparam int ST_AT_ZERO    = 0;
  localparam int ST_OVERFLOW   = 1;
  localparam int ST_UNDERFLOW  = 2;
  localparam int ST_SNAP_VALID = 3;
  localparam int ST_RUNNING    = 4;
  localparam int ST_USED_BITS  = 5;

  localparam int MODE_SAT = 0;
  localparam int MODE_DIR = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/cnt_tick_gen.sv
// Auto-run prescaler: issues a one-cycle tick every max(period,1) enabled cycles.
// While disabled it keeps reloading, so the period in force at entry is used.
module cnt_tick_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic [PERIOD_W-1:0] reload_s;

  assign tick_o = enable_i && (cnt_q == '0);

  // Reload value and down-count of the prescaler
  always_comb begin
    reload_s = '0;
    cnt_d    = cnt_q;
    if (period_i == '0) begin
      reload_s = '0;
    end else begin
      reload_s = period_i - PERIOD_W'(1);
    end
    if (!enable_i) begin
      cnt_d = reload_s;
    end else if (cnt_q == '0) begin
      cnt_d = reload_s;
    end else begin
      cnt_d = cnt_q - PERIOD_W'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trig_updown_counter.sv
// Trigger-driven up/down counter with atomic snapshot and auto-run mode.
// Optional CNT_SNAP_SEQ_EN adds the capture sequence counter; CNT_W must be 2*HALF_W.
module trig_updown_counter
  import trig_cnt_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int HALF_W   = 16,
  parameter int PERIOD_W = 16
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic [15:0]         trig,
  input  logic [15:0]         mode,
  input  logic [HALF_W-1:0]   step,
  input  logic [PERIOD_W-1:0] period,
  input  logic [HALF_W-1:0]   load_lo,
  input  logic [HALF_W-1:0]   load_hi,
  output logic [CNT_W-1:0]    count,
  output logic [HALF_W-1:0]   snap_lo,
  output logic [HALF_W-1:0]   snap_hi,
  output logic [HALF_W-1:0]   snap_seq,
  output logic [HALF_W-1:0]   status,
  output logic                tc_pulse
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             valid_q, valid_d;
  logic             tc_q, tc_d;
  logic             at_zero_q, at_zero_d;
  run_state_e       state_q, state_d;

  logic [CNT_W:0]   step_ext_s;
  logic [CNT_W:0]   sum_s;
  logic [CNT_W:0]   diff_s;
  logic             tick_s;
  logic             inc_s;
  logic             dec_s;
  logic             ovf_evt_s;
  logic             unf_evt_s;
  logic             unused_s;

  assign unused_s = ^{trig[15:8], mode[15:2]};

  cnt_tick_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_tick_gen (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .enable_i (state_q == RUN),
    .period_i (period),
    .tick_o   (tick_s)
  );

  // Arithmetic is one bit wider so the MSB carries the carry/borrow
  assign step_ext_s = (step == '0) ? (CNT_W+1)'(1) : (CNT_W+1)'(step);
  assign sum_s      = {1'b0, count_q} + step_ext_s;
  assign diff_s     = {1'b0, count_q} - step_ext_s;

  // Next count: clear > load > manual up/down > auto-run tick
  always_comb begin
    count_d   = count_q;
    inc_s     = 1'b0;
    dec_s     = 1'b0;
    ovf_evt_s = 1'b0;
    unf_evt_s = 1'b0;
    if (trig[TRIG_CLEAR]) begin
      count_d = '0;
    end else if (trig[TRIG_LOAD]) begin
      count_d = {load_hi, load_lo};
    end else if (trig[TRIG_UP] ^ trig[TRIG_DOWN]) begin
      inc_s = trig[TRIG_UP];
      dec_s = trig[TRIG_DOWN];
    end else if (tick_s) begin
      inc_s = ~mode[MODE_DIR];
      dec_s = mode[MODE_DIR];
    end else begin
      count_d = count_q;
    end
    if (inc_s) begin
      ovf_evt_s = sum_s[CNT_W];
      count_d   = (sum_s[CNT_W] && mode[MODE_SAT]) ? '1 : sum_s[CNT_W-1:0];
    end else if (dec_s) begin
      unf_evt_s = diff_s[CNT_W];
      count_d   = (diff_s[CNT_W] && mode[MODE_SAT]) ? '0 : diff_s[CNT_W-1:0];
    end else begin
      ovf_evt_s = 1'b0;
      unf_evt_s = 1'b0;
    end
  end

  // Sticky flags (a new event beats clear_flags), terminal-count pulse, snapshot
  always_comb begin
    ovf_d     = (ovf_q & ~trig[TRIG_CLEAR_FLAGS]) | ovf_evt_s;
    unf_d     = (unf_q & ~trig[TRIG_CLEAR_FLAGS]) | unf_evt_s;
    tc_d      = ovf_evt_s | unf_evt_s;
    at_zero_d = (count_d == '0);
    snap_d    = snap_q;
    valid_d   = valid_q;
    if (trig[TRIG_CAPTURE]) begin
      snap_d  = count_q;
      valid_d = 1'b1;
    end else begin
      snap_d  = snap_q;
      valid_d = valid_q;
    end
  end

  // Auto-run FSM; stop wins over start, saturation ends a run in saturate mode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trig[TRIG_RUN_START] && !trig[TRIG_RUN_STOP]) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (trig[TRIG_RUN_STOP] || trig[TRIG_CLEAR] ||
            (mode[MODE_SAT] && (ovf_evt_s || unf_evt_s))) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      count_q   <= '0;
      snap_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      valid_q   <= 1'b0;
      tc_q      <= 1'b0;
      at_zero_q <= 1'b1;
      state_q   <= IDLE;
    end else begin
      count_q   <= count_d;
      snap_q    <= snap_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      valid_q   <= valid_d;
      tc_q      <= tc_d;
      at_zero_q <= at_zero_d;
      state_q   <= state_d;
    end
  end

`ifdef CNT_SNAP_SEQ_EN
  logic [HALF_W-1:0] seq_q, seq_d;

  // Capture sequence number, wraps naturally
  always_comb begin
    if (trig[TRIG_CAPTURE]) begin
      seq_d = seq_q + HALF_W'(1);
    end else begin
      seq_d = seq_q;
    end
  end

  // Sequence register
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign snap_seq = seq_q;
`else
  assign snap_seq = '0;
`endif

  assign count    = count_q;
  assign snap_lo  = snap_q[HALF_W-1:0];
  assign snap_hi  = snap_q[CNT_W-1:HALF_W];
  assign tc_pulse = tc_q;
  assign status   = {{(HALF_W-ST_USED_BITS){1'b0}}, (state_q == RUN), valid_q,
                     unf_q, ovf_q, at_zero_q};

endmodule
